// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and the rotating-priority helper used by the
// Wishbone round-robin arbiter and any other fabric arbiter that needs it.
package wb_arb_pkg;

    localparam int DEF_N_INIT         = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int MAX_INIT           = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // The scan starts just after the previous winner, so every requester is
    // served within n grants no matter how the others behave.
    function automatic logic [MAX_INIT-1:0] rr_pick(input logic [MAX_INIT-1:0] req,
                                                    input logic [2:0]          last,
                                                    input int                  n);
        logic [MAX_INIT-1:0] win;
        logic [2:0]          idx;
        win = '0;
        for (int k = 1; k <= MAX_INIT; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && win == '0 && req[idx]) begin
                win[idx] = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the initiator-side and target-side Wishbone classic signals.
// The master modport is the surrounding environment, the slave modport is the arbiter.
interface wb_rr_arbiter_if #(
    parameter int N_INIT     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [N_INIT*ADDR_WIDTH-1:0] i_adr;
    logic [N_INIT*DATA_WIDTH-1:0] i_dat_w;
    logic [N_INIT*SEL_WIDTH-1:0]  i_sel;
    logic [N_INIT-1:0]            i_cyc;
    logic [N_INIT-1:0]            i_stb;
    logic [N_INIT-1:0]            i_we;
    logic [DATA_WIDTH-1:0]        i_dat_r;
    logic [N_INIT-1:0]            i_ack;
    logic [N_INIT-1:0]            i_err;

    logic [ADDR_WIDTH-1:0]        t_adr;
    logic [DATA_WIDTH-1:0]        t_dat_w;
    logic [SEL_WIDTH-1:0]         t_sel;
    logic                         t_cyc;
    logic                         t_stb;
    logic                         t_we;
    logic [DATA_WIDTH-1:0]        t_dat_r;
    logic                         t_ack;
    logic                         t_err;

    // Drives the initiator requests and plays the target's responses.
    modport master (
        output i_adr, i_dat_w, i_sel, i_cyc, i_stb, i_we,
        input  i_dat_r, i_ack, i_err,
        input  t_adr, t_dat_w, t_sel, t_cyc, t_stb, t_we,
        output t_dat_r, t_ack, t_err
    );

    modport slave (
        input  i_adr, i_dat_w, i_sel, i_cyc, i_stb, i_we,
        output i_dat_r, i_ack, i_err,
        output t_adr, t_dat_w, t_sel, t_cyc, t_stb, t_we,
        input  t_dat_r, t_ack, t_err
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Purely combinational rotating-priority selector over N request bits.
// Returns a one-hot winner, or all zeros when nothing is requested.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N = DEF_N_INIT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant
);

    logic [MAX_INIT-1:0] win;

    always_comb begin
        win   = rr_pick(MAX_INIT'(req), 3'(last), N);
        grant = win[N-1:0];
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic target between N_INIT initiators.
// Define WB_ARB_TIMEOUT_EN to build the watchdog that ends stalled cycles with err.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_INIT         = DEF_N_INIT,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    wb_rr_arbiter_if.slave    bus,
    output logic [N_INIT-1:0] gnt,
    output logic              timeout
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PW        = $clog2(N_INIT);

    arb_state_e        state;
    logic [PW-1:0]     last;
    logic [PW-1:0]     pick_idx;
    logic [N_INIT-1:0] pick;
    logic              wd_fire;

    wb_rr_pick #(.N(N_INIT)) u_pick (
        .req   (bus.i_cyc),
        .last  (last),
        .grant (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_INIT; k++) begin
            if (pick[k]) begin
                pick_idx = PW'(k);
            end
        end
    end

    // last always holds the most recent winner, so it doubles as the owner index while OWNED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            last  <= PW'(N_INIT - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|bus.i_cyc) begin
                        state <= ARB_OWNED;
                        gnt   <= pick;
                        last  <= pick_idx;
                    end
                end
                ARB_OWNED: begin
                    if (!bus.i_cyc[last]) begin
                        state <= ARB_IDLE;
                        gnt   <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.t_cyc   = 1'b0;
        bus.t_stb   = 1'b0;
        bus.t_we    = 1'b0;
        bus.t_adr   = '0;
        bus.t_dat_w = '0;
        bus.t_sel   = '0;
        bus.i_ack   = '0;
        bus.i_err   = '0;
        bus.i_dat_r = bus.t_dat_r;
        if (state == ARB_OWNED) begin
            bus.t_cyc       = bus.i_cyc[last];
            bus.t_stb       = bus.i_stb[last] & ~wd_fire;
            bus.t_we        = bus.i_we[last];
            bus.t_adr       = bus.i_adr[int'(last)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.t_dat_w     = bus.i_dat_w[int'(last)*DATA_WIDTH +: DATA_WIDTH];
            bus.t_sel       = bus.i_sel[int'(last)*SEL_WIDTH +: SEL_WIDTH];
            bus.i_ack[last] = bus.t_ack;
            bus.i_err[last] = bus.t_err | wd_fire;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_count;
    logic          wd_stall;

    assign wd_stall = (state == ARB_OWNED) && bus.i_cyc[last] && bus.i_stb[last]
                      && !bus.t_ack && !bus.t_err;

    // A target termination in the limit cycle clears the count, so it always beats the watchdog.
    always_ff @(posedge clk) begin
        if (reset || state != ARB_OWNED || wd_fire) begin
            wd_count <= '0;
            wd_fire  <= 1'b0;
        end else if (wd_stall) begin
            if (wd_count == CW'(TIMEOUT_CYCLES - 1)) begin
                wd_count <= '0;
                wd_fire  <= 1'b1;
            end else begin
                wd_count <= wd_count + 1'b1;
            end
        end else begin
            wd_count <= '0;
        end
    end

    assign timeout = wd_fire;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter that shares one Wishbone classic target between N_INIT Wishbone initiators, such as several initiator BFMs or a BFM plus RTL masters. Each initiator owns the target for the full duration of its `cyc` assertion, so bursts and read-modify-write sequences are never interleaved. An optional watchdog terminates stalled cycles with `err`. The block sits between the initiators and the single target slave in the testbench or SoC fabric.

## Interface
- N_INIT, 2, number of initiators (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, watchdog limit in stalled cycles (used only with WB_ARB_TIMEOUT_EN; minimum 2)

Clocking and reset: reset reset, synchronous, active-high; clock clk.

- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_adr  in  N_INIT*ADDR_WIDTH  initiator addresses; slice k belongs to initiator k
- i_dat_w  in  N_INIT*DATA_WIDTH  initiator write data
- i_sel  in  N_INIT*SEL_WIDTH  initiator byte selects
- i_cyc, i_stb, i_we  in  N_INIT  initiator control
- i_dat_r  out  DATA_WIDTH  read data, broadcast to all initiators
- i_ack, i_err  out  N_INIT  per-initiator termination
- t_adr  out  ADDR_WIDTH  target address
- t_dat_w  out  DATA_WIDTH  target write data
- t_sel  out  SEL_WIDTH  target byte selects
- t_cyc, t_stb, t_we  out  1  target control
- t_dat_r  in  DATA_WIDTH  target read data
- t_ack, t_err  in  1  target termination
- gnt  out  N_INIT  one-hot registered grant; all-zero when idle
- timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM with two states, IDLE and OWNED. Reset state is IDLE, `gnt`=0, and the round-robin pointer `last`=N_INIT-1, so initiator 0 wins first.
- IDLE: if any `i_cyc` is high, the winner is the first requester in the order last+1, last+2, … (mod N_INIT). On the clock edge: `gnt` becomes one-hot for the winner, `last` is set to the winner, and the FSM goes to OWNED.
- OWNED: the target outputs are combinationally muxed from the granted initiator. `t_ack` and `t_err` are routed only to `i_ack[g]` and `i_err[g]`. All other `i_ack` and `i_err` bits stay 0. `i_dat_r` = `t_dat_r` unconditionally.
- OWNED → IDLE on the edge where `i_cyc[g]`=0; `gnt` clears on that edge. There is no preemption while `i_cyc[g]` is held.
- With `gnt`=0, the target outputs `t_cyc`, `t_stb`, `t_we`, `t_adr`, `t_dat_w` and `t_sel` are all 0.
- Requests arriving during OWNED wait. Deasserting `i_cyc` before grant withdraws the request without side effects.
- Reset asserted mid-cycle: the FSM returns to IDLE and `gnt`=0 on the next edge. `t_cyc` and `t_stb` drop in the same cycle the FSM leaves OWNED. Any in-flight transfer is abandoned without ack.

## Timing
- Grant latency: `i_cyc[k]` sampled high at edge 0 from IDLE → `gnt[k]` and `t_cyc` high after edge 0. The first target cycle is the cycle following the request.
- Release: `i_cyc[g]` low sampled at edge n → IDLE after edge n → next grant after edge n+1. Exactly one dead cycle separates owners.
- Back-to-back ownership by the same sole requester also incurs the one dead cycle.
- Termination paths are zero-latency combinational: `t_ack` → `i_ack[g]`, `t_err` → `i_err[g]`.
- Outputs after reset: `gnt`=0, `timeout`=0, all `i_ack` and `i_err` = 0, all target outputs = 0.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined: a counter increments every OWNED cycle with `t_cyc`&`t_stb`=1 and `t_ack`=`t_err`=0. The counter clears on any `t_ack` or `t_err`, on leaving OWNED, and on reset.
  - When the count reaches TIMEOUT_CYCLES, the next cycle drives `i_err[g]`=1, `timeout`=1, and forces `t_stb`=0 for that single cycle. The counter then clears.
  - If `t_ack` or `t_err` arrives in the same cycle the count would reach the limit, the target termination wins and no timeout occurs.
- Undefined: no counter is built, `timeout` is tied 0, and a stalled target holds the grant indefinitely.

## Structure
- Package `wb_arb_pkg`:
  - FSM state enum (`ARB_IDLE`, `ARB_OWNED`)
  - `rr_pick` function (requests, last → one-hot winner)
  - default width constants
- Sub-module `wb_rr_pick`: purely combinational rotating-priority selector over N_INIT request bits, instanced once. It is reusable by other fabric arbiters.
- Top level contains the FSM, the pointer, the output muxes, and the optional watchdog.

## Test plan
- Single initiator 0 write of adr 0x10, data 0xDEADBEEF:
  - `gnt`=01 one cycle after `i_cyc[0]`
  - the target sees identical adr, data and sel
  - `i_ack[0]` pulses and `i_ack[1]` stays 0
- Both initiators request in the same cycle after reset, three times in a row:
  - grants go 0, 1, 0
  - each grant is separated by exactly one idle cycle
- Initiator 1 holds `cyc` over a 4-beat burst while initiator 0 requests:
  - `gnt` stays 10 for all 4 acks
  - initiator 0 is granted 2 cycles after `i_cyc[1]` falls
- Reset asserted during initiator 0 read:
  - `t_cyc`=0 and `gnt`=0 after the reset edge
  - no ack is routed
  - after release, initiator 0 wins first
- With `WB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=4, target never acks:
  - `i_err[0]` and `timeout` pulse once, on the cycle after 4 stalled cycles
  - `t_stb` is 0 in that cycle
  - the build without the macro hangs, and the bench checks `timeout` stays 0
- Target returns `t_err` while initiator 1 owns the bus:
  - only `i_err[1]` asserts, in the same cycle
  - `i_dat_r` mirrors `t_dat_r` (0xA5A5A5A5)
